// File: rtl/dpu_pkg.sv
// Shared DPU definitions: data width, ALU opcode map and condition-code bit positions.
package dpu_pkg;

    localparam int DW = 8;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NOT  = 4'd6,
        OP_MOVA = 4'd7,
        OP_LOAD = 4'd8,
        OP_INC  = 4'd9,
        OP_DEC  = 4'd10,
        OP_SHL  = 4'd11,
        OP_SHR  = 4'd12,
        OP_CMP  = 4'd13,
        OP_NEG  = 4'd14,
        OP_MOVB = 4'd15
    } op_t;

    localparam int CC_N = 3;
    localparam int CC_Z = 2;
    localparam int CC_V = 1;
    localparam int CC_C = 0;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core: next result, next NZVC flags and the load/write qualifiers.
module alu_comb
    import dpu_pkg::*;
(
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    n,
    output logic [DW-1:0] r,
    output logic [3:0]    cc,
    output logic          tr_load,
    output logic          cc_load,
    output logic          write_qual
);

    op_t           op;
    logic [DW-1:0] add_y;
    logic [DW-1:0] sub_x;
    logic [DW-1:0] sub_y;
    logic [DW:0]   sum;
    logic [DW:0]   diff;
    logic          v;
    logic          c;

    assign op = op_t'(n);

    // One shared adder (ADD/INC) and one shared subtractor (SUB/CMP/DEC/NEG).
    always_comb begin
        add_y = (op == OP_INC) ? DW'(1) : b;
        sub_x = (op == OP_NEG) ? '0 : a;
        if (op == OP_DEC)      sub_y = DW'(1);
        else if (op == OP_NEG) sub_y = a;
        else                   sub_y = b;
    end

    assign sum  = {1'b0, a} + {1'b0, add_y};
    assign diff = {1'b0, sub_x} - {1'b0, sub_y};

    always_comb begin
        r = '0;
        v = 1'b0;
        c = 1'b0;
        case (op)
            OP_ADD, OP_INC: begin
                r = sum[DW-1:0];
                c = sum[DW];
                v = (a[DW-1] == add_y[DW-1]) && (r[DW-1] != a[DW-1]);
            end
            OP_SUB, OP_CMP, OP_DEC, OP_NEG: begin
                r = diff[DW-1:0];
                c = diff[DW];
                v = (sub_x[DW-1] != sub_y[DW-1]) && (r[DW-1] != sub_x[DW-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOT:  r = ~a;
            OP_MOVA: r = a;
            OP_MOVB: r = b;
            OP_SHL: begin
                r = {a[DW-2:0], 1'b0};
                c = a[DW-1];
            end
            OP_SHR: begin
                r = {1'b0, a[DW-1:1]};
                c = a[0];
            end
            default: begin
                r = '0;
            end
        endcase
    end

    always_comb begin
        cc       = '0;
        cc[CC_N] = r[DW-1];
        cc[CC_Z] = (r == '0);
        cc[CC_V] = v;
        cc[CC_C] = c;
    end

    // CMP touches flags only; NOP and the memory-load opcode leave the ALU idle.
    assign cc_load    = (op != OP_NOP) && (op != OP_LOAD);
    assign tr_load    = cc_load && (op != OP_CMP);
    assign write_qual = tr_load;

endmodule

// File: rtl/alu.sv
// Registered 8-bit DPU ALU: output registers around alu_comb with asynchronous active-low reset.
module alu
    import dpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [3:0]    n,
    output logic [3:0]    cc,
    output logic [DW-1:0] tr,
    output logic          write_enable
);

    logic [DW-1:0] r_next;
    logic [3:0]    cc_next;
    logic          tr_load;
    logic          cc_load;
    logic          write_qual;

    logic [DW-1:0] tr_reg;
    logic [3:0]    cc_reg;
    logic          we_reg;

    alu_comb u_comb (
        .a          (a),
        .b          (b),
        .n          (n),
        .r          (r_next),
        .cc         (cc_next),
        .tr_load    (tr_load),
        .cc_load    (cc_load),
        .write_qual (write_qual)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tr_reg <= '0;
            cc_reg <= '0;
            we_reg <= 1'b0;
        end else begin
            we_reg <= write_qual;
            if (tr_load) tr_reg <= r_next;
            if (cc_load) cc_reg <= cc_next;
        end
    end

    assign tr           = tr_reg;
    assign cc           = cc_reg;
    assign write_enable = we_reg;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu: hand-computed vectors, reset behaviour and idle opcodes.
module tb_alu;
    import dpu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] n;
    logic [3:0] cc;
    logic [7:0] tr;
    logic       write_enable;

    int checks_total;
    int checks_passed;

    alu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a),
        .b            (b),
        .n            (n),
        .cc           (cc),
        .tr           (tr),
        .write_enable (write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    endtask

    // Drive on the falling edge, sample 1 ns after the next rising edge.
    task automatic op(input logic [3:0] opc, input logic [7:0] va, input logic [7:0] vb);
        @(negedge clk);
        n = opc;
        a = va;
        b = vb;
        @(posedge clk);
        #1;
        $display("op n=%0d a=%02h b=%02h -> tr=%02h cc=%04b we=%0b", opc, va, vb, tr, cc, write_enable);
    endtask

    task automatic expect_out(input string tag, input logic [7:0] etr, input logic [3:0] ecc, input logic ewe);
        check({tag, ".tr"}, tr, etr);
        check({tag, ".cc"}, {4'b0, cc}, {4'b0, ecc});
        check({tag, ".we"}, {7'b0, write_enable}, {7'b0, ewe});
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n = 1'b0;
        a = 8'h00;
        b = 8'h00;
        n = OP_NOP;
        #1;
        expect_out("reset_init", 8'h00, 4'b0000, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;

        op(OP_ADD, 8'h7F, 8'h01);  expect_out("add_ovf",   8'h80, 4'b1010, 1'b1);
        op(OP_ADD, 8'hFF, 8'h01);  expect_out("add_carry", 8'h00, 4'b0101, 1'b1);
        op(OP_SUB, 8'h03, 8'h05);  expect_out("sub_borrow",8'hFE, 4'b1001, 1'b1);
        op(OP_CMP, 8'h05, 8'h05);  expect_out("cmp_eq",    8'hFE, 4'b0100, 1'b0);
        op(OP_SUB, 8'h80, 8'h01);  expect_out("sub_ovf",   8'h7F, 4'b0010, 1'b1);
        op(OP_AND, 8'hF0, 8'h3C);  expect_out("and",       8'h30, 4'b0000, 1'b1);
        op(OP_OR,  8'hF0, 8'h3C);  expect_out("or",        8'hFC, 4'b1000, 1'b1);
        op(OP_XOR, 8'hF0, 8'h3C);  expect_out("xor",       8'hCC, 4'b1000, 1'b1);
        op(OP_NOT, 8'hF0, 8'h3C);  expect_out("not",       8'h0F, 4'b0000, 1'b1);
        op(OP_MOVA,8'hA5, 8'h3C);  expect_out("mova",      8'hA5, 4'b1000, 1'b1);
        op(OP_SHL, 8'h81, 8'h00);  expect_out("shl",       8'h02, 4'b0001, 1'b1);
        op(OP_SHR, 8'h81, 8'h00);  expect_out("shr",       8'h40, 4'b0001, 1'b1);
        op(OP_INC, 8'h81, 8'h00);  expect_out("inc",       8'h82, 4'b1000, 1'b1);
        op(OP_INC, 8'h7F, 8'h00);  expect_out("inc_ovf",   8'h80, 4'b1010, 1'b1);
        op(OP_DEC, 8'h00, 8'h00);  expect_out("dec_wrap",  8'hFF, 4'b1001, 1'b1);
        op(OP_NEG, 8'h80, 8'h00);  expect_out("neg_80",    8'h80, 4'b1011, 1'b1);
        op(OP_NEG, 8'h01, 8'h00);  expect_out("neg_01",    8'hFF, 4'b1001, 1'b1);
        op(OP_NEG, 8'h00, 8'h00);  expect_out("neg_00",    8'h00, 4'b0100, 1'b1);

        op(OP_ADD, 8'h7F, 8'h01);  expect_out("add_pre_ld",8'h80, 4'b1010, 1'b1);
        op(OP_LOAD,8'h11, 8'h22);  expect_out("load_idle", 8'h80, 4'b1010, 1'b0);
        op(OP_NOP, 8'h33, 8'h44);  expect_out("nop_idle",  8'h80, 4'b1010, 1'b0);
        op(OP_MOVB,8'h00, 8'h5A);  expect_out("movb",      8'h5A, 4'b0000, 1'b1);
        op(OP_MOVB,8'h00, 8'h5A);  expect_out("movb_held", 8'h5A, 4'b0000, 1'b1);

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 8'h00, 4'b0000, 1'b0);

        n = OP_ADD;
        a = 8'h7F;
        b = 8'h01;
        repeat (2) @(posedge clk);
        #1;
        expect_out("add_in_rst", 8'h00, 4'b0000, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        n = OP_ADD;
        a = 8'h01;
        b = 8'h02;
        @(posedge clk);
        #1;
        expect_out("first_after_rst", 8'h03, 4'b0000, 1'b1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
